// File: rtl/mmu_tlb.sv
// mmu_tlb
//   Virtual-to-physical translation for the instruction and data sides.
//   kseg0/kseg1 are fixed maps. Every other segment goes through a
//   software-managed MIPS32-style TLB with 4 KB pages held as even/odd pairs.
//   Lookups are registered, so results appear one cycle after the request.
//   CP0 drives the TLB maintenance operations TLBWI, TLBWR, TLBP and TLBR.
//
// Ports
//   clk, resetn                      clock, asynchronous active-low reset
//   asid, k0_cca                     current ASID, kseg0 cacheability (2 = uncached)
//   inst_req/inst_vaddr              instruction lookup request
//   inst_valid/paddr/refill/invalid  instruction result (pulse one cycle later)
//   data_req/data_wr/data_vaddr      data lookup request (data_wr = store)
//   data_valid/paddr/uncached/
//     refill/invalid/modified        data result (pulse one cycle later)
//   tlb_op                           0 none, 1 TLBWI, 2 TLBWR, 3 TLBP, 4 TLBR
//   index_in, wired_in, wired_we     Index and Wired registers
//   entryhi_in, entrylo0_in/1_in     EntryHi and EntryLo0/EntryLo1
//   op_done, probe_miss, probe_index TLBP/TLBR completion and probe result
//   rd_entryhi, rd_entrylo0/1        TLBR read-back
//   random_out                       Random register
module mmu_tlb #(
  parameter int TLB_ENTRIES    = 16,
  parameter int IDX_W          = $clog2(TLB_ENTRIES),
  parameter bit FORCE_UNCACHED = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       asid,
  input  logic [2:0]       k0_cca,
  input  logic             inst_req,
  input  logic [31:0]      inst_vaddr,
  output logic             inst_valid,
  output logic [31:0]      inst_paddr,
  output logic             inst_refill,
  output logic             inst_invalid,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [31:0]      data_vaddr,
  output logic             data_valid,
  output logic [31:0]      data_paddr,
  output logic             data_uncached,
  output logic             data_refill,
  output logic             data_invalid,
  output logic             data_modified,
  input  logic [2:0]       tlb_op,
  input  logic [IDX_W-1:0] index_in,
  input  logic [IDX_W-1:0] wired_in,
  input  logic             wired_we,
  input  logic [31:0]      entryhi_in,
  input  logic [25:0]      entrylo0_in,
  input  logic [25:0]      entrylo1_in,
  output logic             op_done,
  output logic             probe_miss,
  output logic [IDX_W-1:0] probe_index,
  output logic [31:0]      rd_entryhi,
  output logic [25:0]      rd_entrylo0,
  output logic [25:0]      rd_entrylo1,
  output logic [IDX_W-1:0] random_out
);

  localparam logic [2:0]       OP_TLBWI = 3'd1;
  localparam logic [2:0]       OP_TLBWR = 3'd2;
  localparam logic [2:0]       OP_TLBP  = 3'd3;
  localparam logic [2:0]       OP_TLBR  = 3'd4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        uncached;
    logic        refill;
    logic        invalid;
    logic        modified;
  } xlat_t;

  tlb_entry_t       tlb [TLB_ENTRIES];
  xlat_t            inst_x;
  xlat_t            data_x;
  logic [IDX_W:0]   probe_s;
  logic [IDX_W-1:0] wr_idx;
  tlb_entry_t       new_entry;
  logic             unused_bits;

  // Returns {hit, index}. The scan runs from the top index down, so the
  // lowest matching index is the one that survives when entries overlap.
  function automatic logic [IDX_W:0] search(input logic [18:0] vpn2, input logic [7:0] id);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (tlb[i].vpn2 == vpn2 && (tlb[i].g || tlb[i].asid == id)) begin
        r = {1'b1, IDX_W'(i)};
      end
    end
    return r;
  endfunction

  function automatic xlat_t translate(input logic [31:0] va, input logic store);
    xlat_t            r;
    logic [IDX_W:0]   s;
    logic [IDX_W-1:0] idx;
    logic [19:0]      pfn;
    logic [2:0]       c;
    logic             d;
    logic             v;
    r   = '0;
    s   = '0;
    idx = '0;
    pfn = '0;
    c   = '0;
    d   = 1'b0;
    v   = 1'b0;
    if (va[31:30] == 2'b10) begin
      // kseg0/kseg1 bypass the TLB. kseg1 is always uncached.
      r.paddr    = {3'b000, va[28:0]};
      r.uncached = va[29] || (k0_cca == 3'd2);
    end else begin
      s   = search(va[31:13], asid);
      idx = s[IDX_W-1:0];
      pfn = va[12] ? tlb[idx].pfn1 : tlb[idx].pfn0;
      c   = va[12] ? tlb[idx].c1   : tlb[idx].c0;
      d   = va[12] ? tlb[idx].d1   : tlb[idx].d0;
      v   = va[12] ? tlb[idx].v1   : tlb[idx].v0;
      if (!s[IDX_W]) begin
        r.refill = 1'b1;
      end else begin
        r.paddr    = {pfn, va[11:0]};
        r.uncached = (c == 3'd2);
        r.invalid  = !v;
        r.modified = v && store && !d;
      end
    end
    return r;
  endfunction

  always_comb begin
    inst_x    = translate(inst_vaddr, 1'b0);
    data_x    = translate(data_vaddr, data_wr);
    probe_s   = search(entryhi_in[31:13], entryhi_in[7:0]);
    wr_idx    = (tlb_op == OP_TLBWR) ? random_out : index_in;
    new_entry = '{vpn2: entryhi_in[31:13], asid: entryhi_in[7:0],
                  g: entrylo0_in[0] & entrylo1_in[0],
                  pfn0: entrylo0_in[25:6], c0: entrylo0_in[5:3],
                  d0: entrylo0_in[2], v0: entrylo0_in[1],
                  pfn1: entrylo1_in[25:6], c1: entrylo1_in[5:3],
                  d1: entrylo1_in[2], v1: entrylo1_in[1]};
  end

  // The instruction side has no cacheability output and never stores.
  assign unused_bits = ^{inst_x.uncached, inst_x.modified, entryhi_in[12:8]};

  // Writes land on the clock edge. A lookup issued in the same cycle as a
  // write therefore sees the old contents.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLB_ENTRIES; i++) tlb[i] <= '0;
    end else if (tlb_op == OP_TLBWI || tlb_op == OP_TLBWR) begin
      tlb[wr_idx] <= new_entry;
    end
  end

  // Random counts down from the top and wraps back at Wired. The wrap also
  // happens when Wired is written.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random_out <= LAST_IDX;
    end else if (wired_we || wired_in >= LAST_IDX || random_out == wired_in) begin
      random_out <= LAST_IDX;
    end else begin
      random_out <= random_out - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_valid    <= 1'b0;
      inst_paddr    <= '0;
      inst_refill   <= 1'b0;
      inst_invalid  <= 1'b0;
      data_valid    <= 1'b0;
      data_paddr    <= '0;
      data_uncached <= 1'b0;
      data_refill   <= 1'b0;
      data_invalid  <= 1'b0;
      data_modified <= 1'b0;
    end else begin
      inst_valid <= inst_req;
      data_valid <= data_req;
      if (inst_req) begin
        inst_paddr   <= inst_x.paddr;
        inst_refill  <= inst_x.refill;
        inst_invalid <= inst_x.invalid;
      end
      if (data_req) begin
        data_paddr    <= data_x.paddr;
        data_uncached <= FORCE_UNCACHED ? 1'b1 : data_x.uncached;
        data_refill   <= data_x.refill;
        data_invalid  <= data_x.invalid;
        data_modified <= data_x.modified;
      end
    end
  end

  // Probe and read results are registered. rd_* keep their value until the
  // next TLBR.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_done     <= 1'b0;
      probe_miss  <= 1'b0;
      probe_index <= '0;
      rd_entryhi  <= '0;
      rd_entrylo0 <= '0;
      rd_entrylo1 <= '0;
    end else begin
      op_done <= (tlb_op == OP_TLBP) || (tlb_op == OP_TLBR);
      if (tlb_op == OP_TLBP) begin
        probe_miss  <= !probe_s[IDX_W];
        probe_index <= probe_s[IDX_W] ? probe_s[IDX_W-1:0] : '0;
      end
      if (tlb_op == OP_TLBR) begin
        rd_entryhi  <= {tlb[index_in].vpn2, 5'b00000, tlb[index_in].asid};
        rd_entrylo0 <= {tlb[index_in].pfn0, tlb[index_in].c0, tlb[index_in].d0,
                        tlb[index_in].v0, tlb[index_in].g};
        rd_entrylo1 <= {tlb[index_in].pfn1, tlb[index_in].c1, tlb[index_in].d1,
                        tlb[index_in].v1, tlb[index_in].g};
      end
    end
  end

endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb
//   Scoreboard bench for mmu_tlb (16 entries, per-access cacheability).
//   Each expected result is queued when its request is driven, and is
//   compared when the DUT's registered result appears.
module tb_mmu_tlb;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          clk;
  logic          resetn;
  logic [7:0]    asid;
  logic [2:0]    k0_cca;
  logic          inst_req;
  logic [31:0]   inst_vaddr;
  logic          inst_valid;
  logic [31:0]   inst_paddr;
  logic          inst_refill;
  logic          inst_invalid;
  logic          data_req;
  logic          data_wr;
  logic [31:0]   data_vaddr;
  logic          data_valid;
  logic [31:0]   data_paddr;
  logic          data_uncached;
  logic          data_refill;
  logic          data_invalid;
  logic          data_modified;
  logic [2:0]    tlb_op;
  logic [IW-1:0] index_in;
  logic [IW-1:0] wired_in;
  logic          wired_we;
  logic [31:0]   entryhi_in;
  logic [25:0]   entrylo0_in;
  logic [25:0]   entrylo1_in;
  logic          op_done;
  logic          probe_miss;
  logic [IW-1:0] probe_index;
  logic [31:0]   rd_entryhi;
  logic [25:0]   rd_entrylo0;
  logic [25:0]   rd_entrylo1;
  logic [IW-1:0] random_out;

  int n_vectors     = 0;
  int n_miscompares = 0;

  logic [35:0] data_q [$];
  string       dname_q [$];
  logic [33:0] inst_q [$];
  string       iname_q [$];

  mmu_tlb #(.TLB_ENTRIES(N), .FORCE_UNCACHED(1'b0)) dut (
    .clk(clk), .resetn(resetn), .asid(asid), .k0_cca(k0_cca),
    .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_valid(inst_valid),
    .inst_paddr(inst_paddr), .inst_refill(inst_refill), .inst_invalid(inst_invalid),
    .data_req(data_req), .data_wr(data_wr), .data_vaddr(data_vaddr),
    .data_valid(data_valid), .data_paddr(data_paddr), .data_uncached(data_uncached),
    .data_refill(data_refill), .data_invalid(data_invalid), .data_modified(data_modified),
    .tlb_op(tlb_op), .index_in(index_in), .wired_in(wired_in), .wired_we(wired_we),
    .entryhi_in(entryhi_in), .entrylo0_in(entrylo0_in), .entrylo1_in(entrylo1_in),
    .op_done(op_done), .probe_miss(probe_miss), .probe_index(probe_index),
    .rd_entryhi(rd_entryhi), .rd_entrylo0(rd_entrylo0), .rd_entrylo1(rd_entrylo1),
    .random_out(random_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Expected data result: {paddr, uncached, refill, invalid, modified}.
  function automatic logic [35:0] dx(input logic [31:0] pa, input logic u, input logic r,
                                     input logic i, input logic m);
    return {pa, u, r, i, m};
  endfunction

  task automatic push_data(input logic [31:0] va, input logic wr, input logic [35:0] ex,
                           input string nm);
    data_req = 1'b1; data_vaddr = va; data_wr = wr;
    data_q.push_back(ex); dname_q.push_back(nm);
  endtask

  // Instruction expectation is derived from the data one: same paddr,
  // refill and invalid; no cacheability and no modified on this side.
  task automatic push_inst(input logic [31:0] va, input logic [35:0] dex, input string nm);
    inst_req = 1'b1; inst_vaddr = va;
    inst_q.push_back({dex[35:4], dex[2], dex[1]}); iname_q.push_back(nm);
  endtask

  task automatic tick();
    @(negedge clk);
    data_req = 1'b0; inst_req = 1'b0; data_wr = 1'b0; tlb_op = 3'd0; wired_we = 1'b0;
  endtask

  task automatic tlb_write(input logic [2:0] op, input logic [IW-1:0] idx, input logic [31:0] hi,
                           input logic [25:0] lo0, input logic [25:0] lo1);
    tlb_op = op; index_in = idx; entryhi_in = hi; entrylo0_in = lo0; entrylo1_in = lo1;
    tick();
  endtask

  task automatic test_reset();
    logic [IW-1:0] r;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_vectors++;
    if ({inst_valid, inst_paddr, inst_refill, inst_invalid, data_valid, data_paddr,
         data_uncached, data_refill, data_invalid, data_modified, op_done, probe_miss,
         probe_index, rd_entryhi, rd_entrylo0, rd_entrylo1} !== '0) begin
      n_miscompares++;
      $display("[TB] FAIL reset_outputs: got nonzero outputs, required all zero");
    end
    n_vectors++;
    if (random_out !== 4'd15) begin
      n_miscompares++;
      $display("[TB] FAIL reset_random: got %0d required 15", random_out);
    end
    resetn = 1'b1;
    @(negedge clk);
    r = random_out;
    n_vectors++;
    if (r !== 4'd14) begin
      n_miscompares++;
      $display("[TB] FAIL random_first_dec: got %0d required 14", r);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] va [4];
    logic        wr [4];
    logic [2:0]  k0 [4];
    logic [35:0] ex [4];
    logic [35:0] dexp;
    logic [33:0] iexp;
    string       nm;
    va = '{32'hBFC0_0100, 32'h8000_1000, 32'hA000_0040, 32'h8000_2000};
    wr = '{1'b0, 1'b0, 1'b1, 1'b0};
    k0 = '{3'd3, 3'd3, 3'd3, 3'd2};
    ex[0] = dx(32'h1FC0_0100, 1'b1, 1'b0, 1'b0, 1'b0);
    ex[1] = dx(32'h0000_1000, 1'b0, 1'b0, 1'b0, 1'b0);
    ex[2] = dx(32'h0000_0040, 1'b1, 1'b0, 1'b0, 1'b0);
    ex[3] = dx(32'h0000_2000, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      k0_cca = k0[i];
      push_data(va[i], wr[i], ex[i], $sformatf("unmapped_d%0d", i));
      push_inst(va[i], ex[i], $sformatf("unmapped_i%0d", i));
      tick();
      dexp = data_q.pop_front(); nm = dname_q.pop_front(); n_vectors++;
      if ({data_valid, data_paddr, data_uncached, data_refill, data_invalid, data_modified}
          !== {1'b1, dexp}) begin
        n_miscompares++;
        $display("[TB] FAIL %s: got v=%0b pa=%h flags=%b required v=1 pa=%h flags=%b", nm,
                 data_valid, data_paddr,
                 {data_uncached, data_refill, data_invalid, data_modified}, dexp[35:4], dexp[3:0]);
      end
      iexp = inst_q.pop_front(); nm = iname_q.pop_front(); n_vectors++;
      if ({inst_valid, inst_paddr, inst_refill, inst_invalid} !== {1'b1, iexp}) begin
        n_miscompares++;
        $display("[TB] FAIL %s: got v=%0b pa=%h flags=%b required v=1 pa=%h flags=%b", nm,
                 inst_valid, inst_paddr, {inst_refill, inst_invalid}, iexp[33:2], iexp[1:0]);
      end
    end
    k0_cca = 3'd3;
  endtask

  // Back-to-back requests on both sides across hit, miss, invalid, modified,
  // global and overlapping-entry cases.
  task automatic test_mapped();
    logic [31:0] va [10];
    logic        wr [10];
    logic [7:0]  id [10];
    logic [35:0] ex [10];
    logic [35:0] dexp;
    logic [33:0] iexp;
    string       nm;
    tlb_write(3'd1, 4'd5, 32'h0040_0012, 26'h0048D1E, 26'h0159E18);
    tlb_write(3'd1, 4'd6, 32'h0060_0012, 26'h002AF12, 26'h0);
    tlb_write(3'd1, 4'd7, 32'h0080_0055, 26'h001DDDF, 26'h002221F);
    tlb_write(3'd1, 4'd3, 32'h00A0_0012, 26'h000CCDE, 26'h0);
    tlb_write(3'd1, 4'd2, 32'h00A0_0012, 26'h000889E, 26'h0);
    va = '{32'h0040_0ABC, 32'h0040_0ABC, 32'h0040_1000, 32'h0060_0123, 32'h0060_0123,
           32'h0080_1004, 32'h00A0_0010, 32'h0040_0ABC, 32'h0040_1000, 32'hC000_0000};
    wr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    id = '{8'h12, 8'h13, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12, 8'h12};
    ex[0] = dx(32'h0123_4ABC, 1'b0, 1'b0, 1'b0, 1'b0);
    ex[1] = dx(32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    ex[2] = dx(32'h0567_8000, 1'b0, 1'b0, 1'b1, 1'b0);
    ex[3] = dx(32'h00AB_C123, 1'b1, 1'b0, 1'b0, 1'b1);
    ex[4] = dx(32'h00AB_C123, 1'b1, 1'b0, 1'b0, 1'b0);
    ex[5] = dx(32'h0088_8004, 1'b0, 1'b0, 1'b0, 1'b0);
    ex[6] = dx(32'h0022_2010, 1'b0, 1'b0, 1'b0, 1'b0);
    ex[7] = dx(32'h0123_4ABC, 1'b0, 1'b0, 1'b0, 1'b0);
    ex[8] = dx(32'h0567_8000, 1'b0, 1'b0, 1'b1, 1'b0);
    ex[9] = dx(32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      asid = id[i];
      push_data(va[i], wr[i], ex[i], $sformatf("mapped_d%0d", i));
      push_inst(va[i], ex[i], $sformatf("mapped_i%0d", i));
      @(negedge clk);
      dexp = data_q.pop_front(); nm = dname_q.pop_front(); n_vectors++;
      if ({data_valid, data_paddr, data_uncached, data_refill, data_invalid, data_modified}
          !== {1'b1, dexp}) begin
        n_miscompares++;
        $display("[TB] FAIL %s: got v=%0b pa=%h flags=%b required v=1 pa=%h flags=%b", nm,
                 data_valid, data_paddr,
                 {data_uncached, data_refill, data_invalid, data_modified}, dexp[35:4], dexp[3:0]);
      end
      iexp = inst_q.pop_front(); nm = iname_q.pop_front(); n_vectors++;
      if ({inst_valid, inst_paddr, inst_refill, inst_invalid} !== {1'b1, iexp}) begin
        n_miscompares++;
        $display("[TB] FAIL %s: got v=%0b pa=%h flags=%b required v=1 pa=%h flags=%b", nm,
                 inst_valid, inst_paddr, {inst_refill, inst_invalid}, iexp[33:2], iexp[1:0]);
      end
    end
    data_req = 1'b0; inst_req = 1'b0; data_wr = 1'b0; asid = 8'h12;
  endtask

  task automatic test_probe_read();
    logic [31:0]   hi [4];
    logic [IW+1:0] ex [4];
    logic [IW+1:0] obs;
    hi = '{32'h0040_0012, 32'h1230_0012, 32'h00A0_0012, 32'h0080_0099};
    ex = '{{1'b1, 1'b0, 4'd5}, {1'b1, 1'b1, 4'd0}, {1'b1, 1'b0, 4'd2}, {1'b1, 1'b0, 4'd7}};
    for (int i = 0; i < 4; i++) begin
      tlb_op = 3'd3; entryhi_in = hi[i];
      tick();
      obs = {op_done, probe_miss, probe_index};
      n_vectors++;
      if (obs !== ex[i]) begin
        n_miscompares++;
        $display("[TB] FAIL probe%0d: got done/miss/idx=%b required %b", i, obs, ex[i]);
      end
    end
    tlb_op = 3'd4; index_in = 4'd5;
    tick();
    n_vectors++;
    if ({op_done, rd_entryhi, rd_entrylo0, rd_entrylo1} !==
        {1'b1, 32'h0040_0012, 26'h0048D1E, 26'h0159E18}) begin
      n_miscompares++;
      $display("[TB] FAIL tlbr5: got %b %h %h %h required 1 00400012 048d1e 159e18",
               op_done, rd_entryhi, rd_entrylo0, rd_entrylo1);
    end
    tlb_op = 3'd4; index_in = 4'd7;
    tick();
    tlb_op = 3'd3; entryhi_in = 32'h1230_0012;
    tick();
    n_vectors++;
    if ({op_done, rd_entryhi, rd_entrylo0, rd_entrylo1} !==
        {1'b1, 32'h0080_0055, 26'h001DDDF, 26'h002221F}) begin
      n_miscompares++;
      $display("[TB] FAIL tlbr7_hold: got %b %h %h %h required 1 00800055 01dddf 02221f",
               op_done, rd_entryhi, rd_entrylo0, rd_entrylo1);
    end
    @(negedge clk);
    n_vectors++;
    if (op_done !== 1'b0) begin
      n_miscompares++;
      $display("[TB] FAIL op_done_pulse: got %b required 0", op_done);
    end
  endtask

  task automatic test_random();
    logic [IW-1:0] exp_rand;
    logic [35:0]   dexp;
    logic [IW+1:0] obs;
    string         nm;
    wired_in = 4'd4; wired_we = 1'b1;
    tick();
    exp_rand = 4'd15;
    n_vectors++;
    if (random_out !== exp_rand) begin
      n_miscompares++;
      $display("[TB] FAIL random_wired_we: got %0d required %0d", random_out, exp_rand);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      exp_rand = (exp_rand == 4'd4) ? 4'd15 : exp_rand - 4'd1;
      n_vectors++;
      if (random_out !== exp_rand) begin
        n_miscompares++;
        $display("[TB] FAIL random_step%0d: got %0d required %0d", i, random_out, exp_rand);
      end
    end
    // Model now holds 12, so TLBWR issued here must land in entry 12.
    tlb_write(3'd2, 4'd0, 32'h00E0_0012, 26'h003839E, 26'h0);
    tlb_op = 3'd3; entryhi_in = 32'h00E0_0012;
    tick();
    obs = {op_done, probe_miss, probe_index};
    n_vectors++;
    if (obs !== {1'b1, 1'b0, 4'd12}) begin
      n_miscompares++;
      $display("[TB] FAIL tlbwr_probe: got done/miss/idx=%b required 1_0_1100", obs);
    end
    push_data(32'h00E0_0008, 1'b0, dx(32'h00E0_E008, 1'b0, 1'b0, 1'b0, 1'b0), "tlbwr_lookup");
    tick();
    dexp = data_q.pop_front(); nm = dname_q.pop_front(); n_vectors++;
    if ({data_valid, data_paddr, data_uncached, data_refill, data_invalid, data_modified}
        !== {1'b1, dexp}) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got v=%0b pa=%h required v=1 pa=%h", nm, data_valid,
               data_paddr, dexp[35:4]);
    end
    wired_in = 4'd0;
  endtask

  task automatic test_back_to_back();
    logic [35:0] dexp;
    string       nm;
    // Write and lookup of the same page in one cycle: the lookup sees the old
    // (empty) entry. The following cycle must hit.
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        tlb_op = 3'd1; index_in = 4'd9; entryhi_in = 32'h00C0_0012;
        entrylo0_in = 26'h003031E; entrylo1_in = 26'h0;
        push_data(32'h00C0_0040, 1'b0, dx(32'h0, 1'b0, 1'b1, 1'b0, 1'b0), "same_cycle_old");
      end else begin
        push_data(32'h00C0_0040, 1'b0, dx(32'h00C0_C040, 1'b0, 1'b0, 1'b0, 1'b0),
                  "next_cycle_hit");
      end
      tick();
      dexp = data_q.pop_front(); nm = dname_q.pop_front(); n_vectors++;
      if ({data_valid, data_paddr, data_uncached, data_refill, data_invalid, data_modified}
          !== {1'b1, dexp}) begin
        n_miscompares++;
        $display("[TB] FAIL %s: got v=%0b pa=%h flags=%b required v=1 pa=%h flags=%b", nm,
                 data_valid, data_paddr,
                 {data_uncached, data_refill, data_invalid, data_modified}, dexp[35:4], dexp[3:0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] dexp;
    string       nm;
    data_req = 1'b1; data_vaddr = 32'h0040_0ABC; inst_req = 1'b1; inst_vaddr = 32'h0040_0ABC;
    tlb_op = 3'd3; entryhi_in = 32'h0040_0012;
    #3 resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    data_req = 1'b0; inst_req = 1'b0; tlb_op = 3'd0;
    for (int i = 0; i < 2; i++) begin
      n_vectors++;
      if ({inst_valid, data_valid, op_done} !== 3'b000) begin
        n_miscompares++;
        $display("[TB] FAIL reset_mid_%0d: got inst/data/op=%b required 000", i,
                 {inst_valid, data_valid, op_done});
      end
      if (i == 0) begin
        n_vectors++;
        if (random_out !== 4'd15) begin
          n_miscompares++;
          $display("[TB] FAIL reset_mid_random: got %0d required 15", random_out);
        end
      end
      @(negedge clk);
    end
    push_data(32'h0040_0ABC, 1'b0, dx(32'h0, 1'b0, 1'b1, 1'b0, 1'b0), "cleared_tlb");
    tick();
    dexp = data_q.pop_front(); nm = dname_q.pop_front(); n_vectors++;
    if ({data_valid, data_paddr, data_uncached, data_refill, data_invalid, data_modified}
        !== {1'b1, dexp}) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got v=%0b pa=%h refill=%b required v=1 pa=%h refill=1", nm,
               data_valid, data_paddr, data_refill, dexp[35:4]);
    end
  endtask

  initial begin
    resetn = 1'b0; asid = 8'h12; k0_cca = 3'd3;
    inst_req = 1'b0; inst_vaddr = '0; data_req = 1'b0; data_wr = 1'b0; data_vaddr = '0;
    tlb_op = 3'd0; index_in = '0; wired_in = '0; wired_we = 1'b0;
    entryhi_in = '0; entrylo0_in = '0; entrylo1_in = '0;
    test_reset();
    test_unmapped();
    test_mapped();
    test_probe_read();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
